// File: rtl/decimator_pkg.sv
// Shared types and helpers for the multi-channel decimator.
// The optional DECIMATOR_PHASE_EN macro enables a programmable kept-sample phase.
package decimator_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_CH     = 2;
    localparam int MAX_DEC    = 16;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    typedef enum logic {LOAD, RUN} dec_state_t;

    // Zero means "no decimation"; anything above max_dec is clamped.
    function automatic int unsigned sanitise_factor(input int unsigned req,
                                                    input int unsigned max_dec);
        if (req == 0)
            return 1;
        else if (req > max_dec)
            return max_dec;
        else
            return req;
    endfunction

endpackage

// File: rtl/decimator_phase_ctrl.sv
// Frame counter, factor/phase latching and keep strobe for decimator_mc.
// Optional kept-sample phase input under DECIMATOR_PHASE_EN.
module decimator_phase_ctrl
    import decimator_pkg::*;
#(
    parameter int MAX_DEC = decimator_pkg::MAX_DEC,
    parameter int CNT_W   = $clog2(MAX_DEC + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_enable,
    input  logic             sync_clr,
    input  logic             in_valid,
    input  logic [CNT_W-1:0] dec_factor,
`ifdef DECIMATOR_PHASE_EN
    input  logic [CNT_W-1:0] dec_phase,
`endif
    output logic             keep,
    output logic [CNT_W-1:0] factor_act,
    output dec_state_t       state_dbg
);

    dec_state_t       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] factor_nx;
    logic [CNT_W-1:0] phase_act, phase_nx;
    logic [CNT_W-1:0] req_factor;
    logic [CNT_W-1:0] req_phase;
    logic             accept;

    assign accept     = clk_enable && in_valid;
    assign req_factor = CNT_W'(sanitise_factor(32'(dec_factor), MAX_DEC));

`ifdef DECIMATOR_PHASE_EN
    assign req_phase = (dec_phase >= req_factor) ? req_factor - CNT_W'(1) : dec_phase;
`else
    assign req_phase = '0;
`endif

    assign state_dbg = state;

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        factor_nx = factor_act;
        phase_nx  = phase_act;
        keep      = 1'b0;
        if (sync_clr) begin
            // Restart wins over any sample arriving in the same cycle.
            state_nx = LOAD;
            cnt_nx   = '0;
        end else begin
            case (state)
                LOAD: begin
                    state_nx  = RUN;
                    factor_nx = req_factor;
                    phase_nx  = req_phase;
                    cnt_nx    = '0;
                    if (accept) begin
                        keep = (req_phase == '0);
                        if (req_factor != CNT_W'(1))
                            cnt_nx = CNT_W'(1);
                    end
                end
                RUN: begin
                    if (accept) begin
                        keep = (cnt == phase_act);
                        // New factor/phase only take effect at a frame boundary.
                        if (cnt == factor_act - CNT_W'(1)) begin
                            cnt_nx    = '0;
                            factor_nx = req_factor;
                            phase_nx  = req_phase;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nx = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            cnt        <= '0;
            factor_act <= CNT_W'(1);
            phase_act  <= '0;
        end else if (clk_enable) begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            factor_act <= factor_nx;
            phase_act  <= phase_nx;
        end
    end

endmodule

// File: rtl/decimator_mc.sv
// Multi-channel runtime-programmable down-sampler: keeps one of every M accepted samples.
// Define DECIMATOR_PHASE_EN to add the dec_phase port selecting which sample is kept.
module decimator_mc
    import decimator_pkg::*;
#(
    parameter int DATA_WIDTH = decimator_pkg::DATA_WIDTH,
    parameter int NUM_CH     = decimator_pkg::NUM_CH,
    parameter int MAX_DEC    = decimator_pkg::MAX_DEC,
    parameter int CNT_W      = $clog2(MAX_DEC + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clk_enable,
    input  logic                         sync_clr,
    input  logic [CNT_W-1:0]             dec_factor,
`ifdef DECIMATOR_PHASE_EN
    input  logic [CNT_W-1:0]             dec_phase,
`endif
    input  logic                         in_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] dec_in,
    output logic                         out_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] dec_out,
    output logic [CNT_W-1:0]             factor_act,
    output dec_state_t                   state_dbg
);

    logic keep;

    decimator_phase_ctrl #(
        .MAX_DEC (MAX_DEC),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_enable (clk_enable),
        .sync_clr   (sync_clr),
        .in_valid   (in_valid),
        .dec_factor (dec_factor),
`ifdef DECIMATOR_PHASE_EN
        .dec_phase  (dec_phase),
`endif
        .keep       (keep),
        .factor_act (factor_act),
        .state_dbg  (state_dbg)
    );

    // out_valid is a one-cycle pulse; it is frozen along with everything else on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_valid <= 1'b0;
        else if (clk_enable)
            out_valid <= keep;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] out_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                out_q <= '0;
            else if (clk_enable && keep)
                out_q <= dec_in[c*DATA_WIDTH +: DATA_WIDTH];
        end

        assign dec_out[c*DATA_WIDTH +: DATA_WIDTH] = out_q;
    end

endmodule
